// File: rtl/compair_row_group_ctrl_pkg.sv
// Shared types and helpers for the CompAIR row group controller: group sizing,
// row-to-group mapping and the grant arbiter state encoding.
package compair_row_pkg;

    localparam int DEFAULT_RST_MIN_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    function automatic int num_groups(input int num_rows, input int rows_per_group);
        return (num_rows + rows_per_group - 1) / rows_per_group;
    endfunction

    function automatic int row_group(input int row, input int rows_per_group);
        return row / rows_per_group;
    endfunction

    // Row index width, kept at least one bit so a single-row build still has a port.
    function automatic int row_idx_w(input int num_rows);
        return (num_rows > 1) ? $clog2(num_rows) : 1;
    endfunction

endpackage

// File: rtl/compair_row_group_ctrl_if.sv
// Grant handshake between the row arbiter (master) and the readout engine (slave).
interface compair_row_group_ctrl_if
    import compair_row_pkg::*;
#(
    parameter int NUM_ROWS = 20
);
    localparam int ROW_W = row_idx_w(NUM_ROWS);

    logic             grant_valid;
    logic [ROW_W-1:0] grant_row;
    logic             grant_ready;
    logic             grant_done;
    logic             grant_abort;

    modport master (
        output grant_valid, grant_row, grant_abort,
        input  grant_ready, grant_done
    );

    modport slave (
        input  grant_valid, grant_row, grant_abort,
        output grant_ready, grant_done
    );

endinterface

// File: rtl/compair_row_group_ctrl_reset_stretch.sv
// One group's reset stretcher: a reloadable down-counter whose next value decides a
// glitch-free registered active-low reset, asserted from power-on until the count expires.
module compair_group_reset_stretch
    import compair_row_pkg::*;
#(
    parameter int RST_MIN_CYCLES = DEFAULT_RST_MIN_CYCLES
)(
    input  logic sysclk,
    input  logic rst,
    input  logic req,
    output logic group_resn,
    output logic group_in_reset
);
    localparam int               CNT_W    = $clog2(RST_MIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_MIN_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (req) begin
            cnt_next = CNT_LOAD;
        end else if (cnt != '0) begin
            cnt_next = cnt - 1'b1;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            cnt        <= CNT_LOAD;
            group_resn <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            group_resn <= (cnt_next == '0);
        end
    end

    assign group_in_reset = ~group_resn;

endmodule

// File: rtl/compair_row_group_ctrl.sv
// CompAIR row management: per-group chip reset stretching, interrupt synchronisation and
// round-robin grant arbitration. Define COMPAIR_ROW_INT_STATS_EN for per-row grant counters.
module compair_row_group_ctrl
    import compair_row_pkg::*;
#(
    parameter  int NUM_ROWS       = 20,
    parameter  int ROWS_PER_GROUP = 4,
    parameter  int RST_MIN_CYCLES = DEFAULT_RST_MIN_CYCLES,
    parameter  int SYNC_STAGES    = 2,
    localparam int NUM_GROUPS     = num_groups(NUM_ROWS, ROWS_PER_GROUP),
    localparam int ROW_W          = row_idx_w(NUM_ROWS)
)(
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic [NUM_ROWS-1:0]   row_resn_req,
    output logic [NUM_GROUPS-1:0] group_resn,
    output logic [NUM_GROUPS-1:0] group_in_reset,
    input  logic [NUM_ROWS-1:0]   row_interruptn,
    input  logic [NUM_ROWS-1:0]   row_int_mask,
    output logic [NUM_ROWS-1:0]   row_hold,
    compair_row_group_ctrl_if.master grant
`ifdef COMPAIR_ROW_INT_STATS_EN
    ,
    input  logic [ROW_W-1:0]      stat_row,
    output logic [15:0]           stat_count
`endif
);
    localparam logic [ROW_W:0]   NROWS_EXT = (ROW_W + 1)'(NUM_ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);

    logic [NUM_ROWS-1:0] row_in_reset;
    logic [NUM_ROWS-1:0] int_sync [SYNC_STAGES];
    logic [NUM_ROWS-1:0] pending;

    arb_state_t       state;
    arb_state_t       state_next;
    logic [ROW_W-1:0] rr_ptr;
    logic [ROW_W-1:0] rr_next;
    logic [ROW_W-1:0] grant_row_q;
    logic             grant_abort_q;
    logic             grant_valid_c;

    logic [NUM_ROWS-1:0] pend_rot;
    logic [ROW_W:0]      pick_off;
    logic [ROW_W:0]      pick_sum;
    logic [ROW_W-1:0]    pick_row;
    logic                pick_found;

    // ---- group reset stretchers
    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
        localparam int LO = g * ROWS_PER_GROUP;
        localparam int HI = (LO + ROWS_PER_GROUP > NUM_ROWS) ? NUM_ROWS - 1
                                                             : LO + ROWS_PER_GROUP - 1;
        compair_group_reset_stretch #(
            .RST_MIN_CYCLES (RST_MIN_CYCLES)
        ) u_stretch (
            .sysclk         (sysclk),
            .rst            (rst),
            .req            (~&row_resn_req[HI:LO]),
            .group_resn     (group_resn[g]),
            .group_in_reset (group_in_reset[g])
        );
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row_map
        assign row_in_reset[r] = group_in_reset[row_group(r, ROWS_PER_GROUP)];
    end

    // ---- interrupt synchronisers, idle high
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                int_sync[s] <= '1;
            end
        end else begin
            int_sync[0] <= row_interruptn;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                int_sync[s] <= int_sync[s-1];
            end
        end
    end

    assign pending = ~int_sync[SYNC_STAGES-1] & ~row_int_mask & ~row_in_reset;

    // ---- round-robin pick: rotate so rr_ptr sits at bit 0, take the lowest set bit
    always_comb begin
        pend_rot   = (pending >> rr_ptr) | (pending << (NUM_ROWS - int'(rr_ptr)));
        pick_found = 1'b0;
        pick_off   = '0;
        for (int j = NUM_ROWS - 1; j >= 0; j--) begin
            if (pend_rot[j]) begin
                pick_found = 1'b1;
                pick_off   = (ROW_W + 1)'(j);
            end
        end
        pick_sum = {1'b0, rr_ptr} + pick_off;
        if (pick_sum >= NROWS_EXT) begin
            pick_sum = pick_sum - NROWS_EXT;
        end
        pick_row = pick_sum[ROW_W-1:0];
    end

    assign rr_next = (grant_row_q == LAST_ROW) ? '0 : grant_row_q + 1'b1;

    // ---- arbiter FSM
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A ready seen together with a pending drop still completes the handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_found) state_next = OFFER;
            OFFER: begin
                if (grant.grant_ready) begin
                    state_next = BUSY;
                end else if (!pending[grant_row_q]) begin
                    state_next = IDLE;
                end
            end
            BUSY:    if (grant.grant_done || row_in_reset[grant_row_q]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_valid_c = (state == OFFER);
        row_hold      = '0;
        if (state == BUSY) begin
            row_hold[grant_row_q] = 1'b1;
        end
    end

    // Done wins over a simultaneous group reset entry, so no abort in that case.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            grant_row_q   <= '0;
            rr_ptr        <= '0;
            grant_abort_q <= 1'b0;
        end else begin
            grant_abort_q <= (state == BUSY) && !grant.grant_done && row_in_reset[grant_row_q];
            if (state == IDLE && pick_found) begin
                grant_row_q <= pick_row;
            end
            if (state == BUSY && (grant.grant_done || row_in_reset[grant_row_q])) begin
                rr_ptr <= rr_next;
            end
        end
    end

    assign grant.grant_valid = grant_valid_c;
    assign grant.grant_row   = grant_row_q;
    assign grant.grant_abort = grant_abort_q;

`ifdef COMPAIR_ROW_INT_STATS_EN
    logic [15:0] stat_cnt [NUM_ROWS];
    logic        accept;

    assign accept = (state == OFFER) && grant.grant_ready;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                stat_cnt[r] <= '0;
            end
            stat_count <= '0;
        end else begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (row_in_reset[r]) begin
                    stat_cnt[r] <= '0;
                end else if (accept && grant_row_q == ROW_W'(r) && stat_cnt[r] != 16'hFFFF) begin
                    stat_cnt[r] <= stat_cnt[r] + 16'd1;
                end
            end
            stat_count <= ({1'b0, stat_row} < NROWS_EXT) ? stat_cnt[stat_row] : 16'd0;
        end
    end
`endif

endmodule

// File: tb/tb_compair_row_group_ctrl.sv
// Randomised bench for compair_row_group_ctrl against a cycle-level behavioural model
// built from reset deadlines, a sample-history queue and a transaction-level arbiter.
module tb_compair_row_group_ctrl;
    import compair_row_pkg::*;

    localparam int NUM_ROWS       = 20;
    localparam int ROWS_PER_GROUP = 4;
    localparam int RST_MIN_CYCLES = 16;
    localparam int SYNC_STAGES    = 2;
    localparam int NUM_GROUPS     = (NUM_ROWS + ROWS_PER_GROUP - 1) / ROWS_PER_GROUP;
    localparam int ROW_W          = $clog2(NUM_ROWS);

    logic                  sysclk = 1'b0;
    logic                  rst;
    logic [NUM_ROWS-1:0]   row_resn_req;
    logic [NUM_ROWS-1:0]   row_interruptn;
    logic [NUM_ROWS-1:0]   row_int_mask;
    logic [NUM_ROWS-1:0]   row_hold;
    logic [NUM_GROUPS-1:0] group_resn;
    logic [NUM_GROUPS-1:0] group_in_reset;
`ifdef COMPAIR_ROW_INT_STATS_EN
    logic [ROW_W-1:0]      stat_row = '0;
    logic [15:0]           stat_count;
`endif

    compair_row_group_ctrl_if #(.NUM_ROWS(NUM_ROWS)) gif ();

    compair_row_group_ctrl #(
        .NUM_ROWS       (NUM_ROWS),
        .ROWS_PER_GROUP (ROWS_PER_GROUP),
        .RST_MIN_CYCLES (RST_MIN_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) dut (
        .sysclk         (sysclk),
        .rst            (rst),
        .row_resn_req   (row_resn_req),
        .group_resn     (group_resn),
        .group_in_reset (group_in_reset),
        .row_interruptn (row_interruptn),
        .row_int_mask   (row_int_mask),
        .row_hold       (row_hold),
        .grant          (gif)
`ifdef COMPAIR_ROW_INT_STATS_EN
        ,
        .stat_row       (stat_row),
        .stat_count     (stat_count)
`endif
    );

    always #5 sysclk = ~sysclk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int                  m_k;
    int                  low_until [NUM_GROUPS];
    bit                  m_in_reset [NUM_GROUPS];
    logic [NUM_ROWS-1:0] raw_q [$];
    logic [NUM_ROWS-1:0] m_sync;
    int                  m_offer;
    int                  m_busy;
    int                  m_start;
    int                  m_last_row;
    bit                  m_abort;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 20)
                $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, m_k);
        end
    endtask

    function automatic int grp(input int r);
        return r / ROWS_PER_GROUP;
    endfunction

    task automatic model_reset();
        m_k = 0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            low_until[g]  = RST_MIN_CYCLES;
            m_in_reset[g] = 1'b1;
        end
        raw_q.delete();
        m_sync     = '1;
        m_offer    = -1;
        m_busy     = -1;
        m_start    = 0;
        m_last_row = 0;
        m_abort    = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic model_step();
        bit pend [NUM_ROWS];
        m_k++;
        for (int r = 0; r < NUM_ROWS; r++)
            pend[r] = !m_sync[r] && !row_int_mask[r] && !m_in_reset[grp(r)];
        m_abort = 1'b0;
        if (m_busy >= 0) begin
            if (gif.grant_done) begin
                m_start = (m_busy + 1) % NUM_ROWS;
                m_busy  = -1;
            end else if (m_in_reset[grp(m_busy)]) begin
                m_abort = 1'b1;
                m_start = (m_busy + 1) % NUM_ROWS;
                m_busy  = -1;
            end
        end else if (m_offer >= 0) begin
            if (gif.grant_ready) begin
                m_busy  = m_offer;
                m_offer = -1;
            end else if (!pend[m_offer]) begin
                m_offer = -1;
            end
        end else begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                int r;
                r = (m_start + i) % NUM_ROWS;
                if (m_offer < 0 && pend[r]) begin
                    m_offer    = r;
                    m_last_row = r;
                end
            end
        end
        for (int g = 0; g < NUM_GROUPS; g++) begin
            for (int r = g * ROWS_PER_GROUP; r < NUM_ROWS && r < (g + 1) * ROWS_PER_GROUP; r++)
                if (!row_resn_req[r]) low_until[g] = m_k + RST_MIN_CYCLES;
            m_in_reset[g] = (m_k < low_until[g]);
        end
        raw_q.push_front(row_interruptn);
        if (raw_q.size() > SYNC_STAGES) void'(raw_q.pop_back());
        m_sync = (raw_q.size() == SYNC_STAGES) ? raw_q[SYNC_STAGES-1] : '1;
    endtask

    task automatic check_outputs();
        logic [31:0] e_resn;
        logic [31:0] e_inrst;
        logic [31:0] e_hold;
        e_resn  = '0;
        e_inrst = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            e_resn[g]  = !m_in_reset[g];
            e_inrst[g] = m_in_reset[g];
        end
        e_hold = (m_busy >= 0) ? (32'd1 << m_busy) : 32'd0;
        chk("group_resn",     32'(group_resn),      e_resn);
        chk("group_in_reset", 32'(group_in_reset),  e_inrst);
        chk("grant_valid",    32'(gif.grant_valid), 32'(m_offer >= 0));
        chk("grant_row",      32'(gif.grant_row),   32'(m_last_row));
        chk("row_hold",       32'(row_hold),        e_hold);
        chk("grant_abort",    32'(gif.grant_abort), 32'(m_abort));
    endtask

    task automatic drive_random();
        for (int r = 0; r < NUM_ROWS; r++) begin
            if ($urandom_range(15, 0) == 0) row_interruptn[r] = ~row_interruptn[r];
            if ($urandom_range(63, 0) == 0) row_int_mask[r]   = ~row_int_mask[r];
            row_resn_req[r] = ($urandom_range(1499, 0) != 0);
        end
        gif.grant_ready = ($urandom_range(2, 0) == 0);
        gif.grant_done  = ($urandom_range(4, 0) == 0);
    endtask

    task automatic run_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge sysclk);
            model_step();
            #1;
            check_outputs();
            drive_random();
        end
    endtask

    initial begin
        rst             = 1'b1;
        row_resn_req    = '1;
        row_interruptn  = '1;
        row_int_mask    = '0;
        gif.grant_ready = 1'b0;
        gif.grant_done  = 1'b0;
        model_reset();
        repeat (3) @(posedge sysclk);
        #1;
        check_outputs();
        row_interruptn[3]  = 1'b0;
        row_interruptn[7]  = 1'b0;
        row_interruptn[19] = 1'b0;
        gif.grant_ready    = 1'b1;
        rst = 1'b0;

        // Directed: power-on, round robin 3/7/19, group 1 re-request, withdrawal, masking
        for (int c = 0; c < 300; c++) begin
            @(posedge sysclk);
            model_step();
            #1;
            check_outputs();
            row_resn_req    = '1;
            gif.grant_done  = ($urandom_range(3, 0) == 0);
            if (c == 40 || c == 50) row_resn_req[5] = 1'b0;
            if (c == 120) begin
                row_interruptn    = '1;
                row_interruptn[9] = 1'b0;
                gif.grant_ready   = 1'b0;
            end
            if (c == 140) row_interruptn[9] = 1'b1;
            if (c == 200) begin
                row_interruptn[2] = 1'b0;
                row_int_mask[2]   = 1'b1;
                gif.grant_ready   = 1'b1;
            end
            if (c == 250) row_int_mask[2] = 1'b0;
        end

        run_random(4000);

        // Asynchronous reset in mid-cycle
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge sysclk);
        #1;
        rst = 1'b0;
        run_random(1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
